xm_result_buffer: RTL

//  Execute-to-memory result stage. Captures each ALU result (and32/or32/adder/shift

---
 rtl/xm_result_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/xm_result_buffer.sv
// rtl/xm_result_buffer.sv - execute-to-memory result stage with 2-entry skid buffer and bypass export
module xm_result_buffer #(
  parameter int WIDTH   = 32,
  parameter int RD_W    = 5,
  parameter int RSTATUS = 30
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_we,
  input  logic             in_ovf,
  input  logic [WIDTH-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_we,
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_result
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nx;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_fire, out_fire;
  logic [WIDTH-1:0] cap_result, skid_result;
  logic [RD_W-1:0]  cap_rd, skid_rd;
  logic             cap_we, skid_we, fwd_we;

  // Overflow on a writing op redirects the write to rstatus with the exception code.
  assign cap_rd     = (in_ovf && in_we) ? RD_W'(RSTATUS) : in_rd;
  assign cap_result = (in_ovf && in_we) ? in_code : in_result;
  assign cap_we     = in_we;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx     = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_nx  = TWO;
          load_skid = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_nx = EMPTY;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nx       = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx       = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_result  <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);
      if (load_main_in) begin
        out_result <= cap_result;
        out_rd     <= cap_rd;
        out_we     <= cap_we;
      end else if (load_main_skid) begin
        out_result <= skid_result;
        out_rd     <= skid_rd;
        out_we     <= skid_we;
      end
      if (load_skid) begin
        skid_result <= cap_result;
        skid_rd     <= cap_rd;
        skid_we     <= cap_we;
      end
    end
  end

  // Bypass always exposes the youngest entry: skid when full, otherwise main.
  assign fwd_rd     = (state == TWO) ? skid_rd : out_rd;
  assign fwd_result = (state == TWO) ? skid_result : out_result;
  assign fwd_we     = (state == TWO) ? skid_we : out_we;
  assign fwd_valid  = out_valid && fwd_we;

endmodule
